spi_flash_target: RTL and testbench

Synthesizable SPI flash responder: the device end of the SPI links that the RAID controller's four flash controllers drive. It decodes a minimal flash command set, serves reads from an internal byte array and accepts programs, with write-enable latch and busy/WIP timing. One instance per drive port lets the RAID array run closed-loop in simulation and on FPGA without real flash parts.

---
 rtl/spi_flash_target_pkg.sv | 33 +++
 rtl/spi_target_sync.sv | 45 ++++
 rtl/spi_flash_target.sv | 197 +++++++++++++++++++
 tb/tb_spi_flash_target.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_target_pkg.sv
// Shared definitions for the SPI flash responder: supported opcodes,
// FSM state encoding and the status register layout.
package spi_flash_target_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PROG = 8'h02;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_READ,
    ST_PROG,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    logic [7:0] s;
    s         = '0;
    s[SR_WEL] = wel;
    s[SR_WIP] = wip;
    return s;
  endfunction

endpackage

// File: rtl/spi_target_sync.sv
// Brings the asynchronous SPI pins into the clk domain and produces
// single-cycle edge strobes.
//   clk, reset            system clock, synchronous active-high reset
//   spi_clk/cs/mosi       raw SPI pins
//   sclk_rise/sclk_fall   one-cycle strobes on synchronized spi_clk edges
//   cs_fall/cs_rise       one-cycle strobes on synchronized select edges
//   mosi_s                synchronized data, aligned with sclk_rise
module spi_target_sync (
  input  logic clk,
  input  logic reset,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [2:0] sclk_h;
  logic [2:0] cs_h;
  logic [1:0] mosi_h;

  // Select history resets to "selected" so that a select already held low
  // across reset is not mistaken for a fresh falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_h <= '0;
      cs_h   <= '0;
      mosi_h <= '0;
    end else begin
      sclk_h <= {sclk_h[1:0], spi_clk};
      cs_h   <= {cs_h[1:0], spi_cs};
      mosi_h <= {mosi_h[0], spi_mosi};
    end
  end

  assign sclk_rise = sclk_h[1] & ~sclk_h[2];
  assign sclk_fall = ~sclk_h[1] & sclk_h[2];
  assign cs_fall   = ~cs_h[1] & cs_h[2];
  assign cs_rise   = cs_h[1] & ~cs_h[2];
  assign mosi_s    = mosi_h[1];

endmodule

// File: rtl/spi_flash_target.sv
// SPI flash responder (mode 0) backed by an internal byte array.
//   clk, reset   system clock, synchronous active-high reset
//   spi_clk      SPI clock from the controller (async, <= clk/8)
//   spi_cs       chip select, active low
//   spi_mosi     serial data in, MSB first
//   spi_miso     serial data out, MSB first, 0 while deselected
//   busy         status WIP bit
//   err          one-cycle pulse on an unsupported opcode
// ADDR_W must lie in 9..16: the high address byte contributes the top
// ADDR_W-8 index bits.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | deselected, waiting for select falling edge
// ST_CMD     | shifting in the opcode byte
// ST_ADDR_HI | shifting in address bits 15:8
// ST_ADDR_LO | shifting in address bits 7:0
// ST_READ    | streaming array bytes out, index auto-increments
// ST_PROG    | writing incoming bytes into the array
// ST_STATUS  | streaming the status byte repeatedly
// ST_IGNORE  | swallowing clocks until deselect, miso held 0
module spi_flash_target
  import spi_flash_target_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int PROG_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy,
  output logic err
);

  localparam int CNT_W = $clog2(PROG_CYCLES + 1);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  spi_target_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .spi_clk   (spi_clk),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_s    (mosi_s)
  );

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt;
  logic [6:0]          shift_in;
  logic [7:0]          shift_out;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-9:0]   addr_hi;
  logic                op_prog, prog_done;
  logic                wel, wip;
  logic [CNT_W-1:0]    wip_cnt;
  logic [7:0]          mem [0:(1<<ADDR_W)-1];

  logic [7:0]          byte_in;
  logic                byte_done;
  logic [ADDR_W-1:0]   rd_idx, addr_inc;
  logic                set_wel, clr_wel, start_prog, err_d;

  assign byte_in   = {shift_in, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign rd_idx    = {addr_hi, byte_in};
  assign addr_inc  = addr + ADDR_W'(1);
  assign busy      = wip;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    set_wel    = 1'b0;
    clr_wel    = 1'b0;
    start_prog = 1'b0;
    err_d      = 1'b0;
    if (cs_rise) begin
      state_d    = ST_IDLE;
      start_prog = (state_q == ST_PROG) && prog_done;
    end else begin
      case (state_q)
        ST_IDLE:    if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if (wip && byte_in != OP_RDSR) begin
              state_d = ST_IGNORE;
            end else begin
              case (byte_in)
                OP_READ: state_d = ST_ADDR_HI;
                OP_PROG: state_d = wel ? ST_ADDR_HI : ST_IGNORE;
                OP_WREN: begin set_wel = 1'b1; state_d = ST_IGNORE; end
                OP_WRDI: begin clr_wel = 1'b1; state_d = ST_IGNORE; end
                OP_RDSR: state_d = ST_STATUS;
                default: begin err_d = 1'b1; state_d = ST_IGNORE; end
              endcase
            end
          end
        end
        ST_ADDR_HI: if (byte_done) state_d = ST_ADDR_LO;
        ST_ADDR_LO: if (byte_done) state_d = op_prog ? ST_PROG : ST_READ;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      addr      <= '0;
      addr_hi   <= '0;
      op_prog   <= 1'b0;
      prog_done <= 1'b0;
      wel       <= 1'b0;
      wip       <= 1'b0;
      wip_cnt   <= '0;
      err       <= 1'b0;
      spi_miso  <= 1'b0;
    end else begin
      err <= err_d;

      if (cs_rise || state_q == ST_IDLE) bit_cnt <= '0;
      else if (sclk_rise)                bit_cnt <= bit_cnt + 3'd1;
      if (sclk_rise) shift_in <= byte_in[6:0];

      if (set_wel)                     wel <= 1'b1;
      else if (clr_wel || start_prog)  wel <= 1'b0;

      // WIP down-counter: clears on the cycle the count hits zero, giving
      // exactly PROG_CYCLES high cycles.
      if (start_prog) begin
        wip     <= 1'b1;
        wip_cnt <= CNT_W'(PROG_CYCLES);
      end else if (wip) begin
        wip_cnt <= wip_cnt - CNT_W'(1);
        if (wip_cnt == CNT_W'(1)) wip <= 1'b0;
      end

      if (state_q == ST_IDLE) prog_done <= 1'b0;

      if (byte_done) begin
        case (state_q)
          ST_CMD: begin
            op_prog   <= (byte_in == OP_PROG);
            shift_out <= status_byte(wel, wip);
          end
          ST_ADDR_HI: addr_hi <= byte_in[ADDR_W-9:0];
          ST_ADDR_LO: begin
            addr      <= rd_idx;
            shift_out <= mem[rd_idx];
          end
          ST_READ: begin
            addr      <= addr_inc;
            shift_out <= mem[addr_inc];
          end
          ST_PROG: begin
            addr      <= addr_inc;
            prog_done <= 1'b1;
          end
          ST_STATUS: shift_out <= status_byte(wel, wip);
          default:   ;
        endcase
      end

      // Output bits change on spi_clk fall so they are stable for the
      // controller's sampling rise; a byte reload on the 8th rise is picked
      // up by the following fall.
      if (cs_rise || state_q == ST_IDLE) begin
        spi_miso <= 1'b0;
      end else if (sclk_fall) begin
        if (state_q == ST_READ || state_q == ST_STATUS) begin
          spi_miso  <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end else begin
          spi_miso <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && byte_done && state_q == ST_PROG) mem[addr] <= byte_in;
  end

endmodule

// File: tb/tb_spi_flash_target.sv
module tb_spi_flash_target;

  localparam int HP = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_cs = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, busy, err;

  spi_flash_target #(.ADDR_W(10), .PROG_CYCLES(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // busy / err pulse monitors
  int busy_run = 0, last_busy = 0;
  int err_run = 0, err_pulses = 0, err_max = 0;
  always @(posedge clk) begin
    if (busy === 1'b1) busy_run <= busy_run + 1;
    else begin
      if (busy_run != 0) last_busy <= busy_run;
      busy_run <= 0;
    end
    if (err === 1'b1) err_run <= err_run + 1;
    else begin
      if (err_run != 0) begin
        err_pulses <= err_pulses + 1;
        if (err_run > err_max) err_max <= err_run;
      end
      err_run <= 0;
    end
  end

  // reference model state
  logic [7:0] ref_mem [0:1023];
  logic       ref_wel = 1'b0;
  logic       ref_wip = 1'b0;
  int         exp_err = 0;
  logic [7:0] tx [0:15];
  logic [7:0] rx [0:15];
  logic [7:0] ex [0:15];

  task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = t[i];
      #(HP);
      r[i] = spi_miso;
      spi_clk = 1'b1;
      #(HP);
      spi_clk = 1'b0;
    end
  endtask

  task automatic run_xact(input int n);
    spi_cs = 1'b0;
    #60;
    for (int k = 0; k < n; k++) spi_byte(tx[k], rx[k]);
    #60;
    spi_cs = 1'b1;
    #100;
  endtask

  // Transaction-level behaviour of the flash part.
  task automatic model_xact(input int n);
    logic [7:0] op;
    int base;
    op   = tx[0];
    base = int'({tx[1], tx[2]}) % 1024;
    for (int k = 0; k < 16; k++) ex[k] = 8'h00;
    if (ref_wip && op != 8'h05) return;
    case (op)
      8'h03: for (int k = 3; k < n; k++) ex[k] = ref_mem[(base + k - 3) % 1024];
      8'h02: if (ref_wel) begin
        for (int k = 3; k < n; k++) ref_mem[(base + k - 3) % 1024] = tx[k];
        if (n > 3) begin ref_wel = 1'b0; ref_wip = 1'b1; end
      end
      8'h06: ref_wel = 1'b1;
      8'h04: ref_wel = 1'b0;
      8'h05: for (int k = 1; k < n; k++) ex[k] = {6'b0, ref_wel, ref_wip};
      default: exp_err++;
    endcase
  endtask

  task automatic xfer(input string tag, input logic [7:0] op, input logic [15:0] a, input int n);
    tx[0] = op;
    tx[1] = a[15:8];
    tx[2] = a[7:0];
    model_xact(n);
    run_xact(n);
    for (int k = 0; k < n; k++) check_val($sformatf("%s_rx%0d", tag, k), rx[k], ex[k]);
    check_val({tag, "_busy"}, busy, ref_wip);
    check_val({tag, "_errcnt"}, err_pulses, exp_err);
  endtask

  task automatic wait_prog(input string tag);
    for (int c = 0; c < 300 && busy === 1'b1; c++) @(negedge clk);
    check_val({tag, "_busy_drop"}, busy, 0);
    repeat (2) @(negedge clk);
    check_val({tag, "_busy_len"}, last_busy, 64);
    ref_wip = 1'b0;
  endtask

  initial begin
    logic [7:0] dummy;
    int a, len;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_miso", spi_miso, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_err", err, 0);
    #3;

    // program + RDSR poll + readback
    xfer("wren1", 8'h06, 16'h0, 1);
    tx[3] = 8'hA5; tx[4] = 8'h3C;
    xfer("prog1", 8'h02, 16'h0010, 5);
    for (int p = 0; p < 10; p++) begin
      tx[0] = 8'h05; tx[1] = 8'h00;
      run_xact(2);
      check_val("poll_wel", rx[1][1], 0);
      if (rx[1][0] == 1'b0) break;
    end
    check_val("poll_wip", rx[1][0], 0);
    check_val("prog1_busy_len", last_busy, 64);
    ref_wip = 1'b0;
    xfer("read1", 8'h03, 16'h0010, 5);
    check_val("read1_a5", rx[3], 8'hA5);

    // program without WREN is ignored
    xfer("wren2", 8'h06, 16'h0, 1);
    tx[3] = 8'h11;
    xfer("prog2", 8'h02, 16'h0020, 4);
    wait_prog("prog2");
    tx[3] = 8'h55;
    xfer("prog_nowel", 8'h02, 16'h0020, 4);
    xfer("read2", 8'h03, 16'h0020, 4);
    xfer("rdsr2", 8'h05, 16'h0, 2);

    // WEL set / clear
    xfer("wren3", 8'h06, 16'h0, 1);
    xfer("rdsr3a", 8'h05, 16'h0, 3);
    xfer("wrdi3", 8'h04, 16'h0, 1);
    xfer("rdsr3b", 8'h05, 16'h0, 2);

    // index wrap and address aliasing
    xfer("wren4", 8'h06, 16'h0, 1);
    tx[3] = 8'hD0; tx[4] = 8'hD1; tx[5] = 8'hD2;
    xfer("prog4", 8'h02, 16'h03FF, 6);
    wait_prog("prog4");
    xfer("read4", 8'h03, 16'h03FF, 5);
    xfer("read4_alias", 8'h03, 16'h0401, 4);

    // unsupported opcode
    tx[3] = 8'hAA; tx[4] = 8'h55;
    xfer("badop", 8'h9F, 16'hAA55, 5);
    xfer("rdsr5", 8'h05, 16'h0, 2);
    check_val("err_width", err_max, 1);

    // reset in the middle of a program data byte
    xfer("wren6", 8'h06, 16'h0, 1);
    spi_cs = 1'b0;
    #60;
    spi_byte(8'h02, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h20, dummy);
    for (int i = 0; i < 4; i++) begin
      spi_mosi = 1'b1; #(HP); spi_clk = 1'b1; #(HP); spi_clk = 1'b0;
    end
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ref_wel = 1'b0;
    #3;
    for (int i = 0; i < 4; i++) begin
      spi_mosi = 1'b1; #(HP); spi_clk = 1'b1; #(HP); spi_clk = 1'b0;
    end
    #60;
    spi_cs = 1'b1;
    repeat (80) @(negedge clk);
    check_val("rstprog_busy", busy, 0);
    #3;
    xfer("rstprog_rdsr", 8'h05, 16'h0, 2);
    xfer("rstprog_read", 8'h03, 16'h0020, 4);
    xfer("wren7", 8'h06, 16'h0, 1);
    tx[3] = 8'h77;
    xfer("prog7", 8'h02, 16'h0020, 4);
    wait_prog("prog7");
    xfer("read7", 8'h03, 16'h0020, 4);

    // randomized program / readback
    for (int it = 0; it < 8; it++) begin
      a   = $urandom_range(0, 65535);
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) tx[3 + k] = 8'($urandom);
      xfer($sformatf("rnd%0d_wren", it), 8'h06, 16'h0, 1);
      for (int k = 0; k < len; k++) tx[3 + k] = ref_mem[0] ^ 8'($urandom);
      xfer($sformatf("rnd%0d_prog", it), 8'h02, 16'(a), 3 + len);
      wait_prog($sformatf("rnd%0d", it));
      xfer($sformatf("rnd%0d_read", it), 8'h03, 16'(a), 3 + len);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
